// File: rtl/tracker_pkg.sv
// Shared definitions for the solar-tracker axis sequencers and max_counter:
// default widths, servo direction encoding, sequencer states and the
// per-state decode of the registered control strobes.
package tracker_pkg;

  // Default widths; max_counter uses the same count width as the sequencer.
  localparam int DEF_CW = 15;
  localparam int DEF_VW = 12;

  // Servo direction encoding.
  localparam logic DIR_FWD  = 1'b0;  // toward 180 degrees
  localparam logic DIR_BACK = 1'b1;  // toward 0 degrees

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_SWEEP   = 3'd2,
    ST_ARM     = 3'd3,
    ST_RETURN  = 3'd4,
    ST_RELEASE = 3'd5
  } sweep_state_t;

  // Control strobes driven by the sequencer, all registered.
  typedef struct packed {
    logic mc;
    logic cnt_rst;
    logic move;
    logic dir;
    logic busy;
    logic done;
  } sweep_ctl_t;

  // Moore decode of the strobes for a given state.
  function automatic sweep_ctl_t f_decode(input sweep_state_t st);
    sweep_ctl_t c;
    c = '0;
    c.dir = DIR_FWD;
    case (st)
      ST_IDLE: begin
        c = '0;
      end
      ST_CLEAR: begin
        c.cnt_rst = 1'b1;
        c.busy    = 1'b1;
      end
      ST_SWEEP: begin
        c.move = 1'b1;
        c.dir  = DIR_FWD;
        c.busy = 1'b1;
      end
      ST_ARM: begin
        // Direction flips only once RETURN starts, so the servo sees one
        // idle cycle before reversing.
        c.mc   = 1'b1;
        c.busy = 1'b1;
      end
      ST_RETURN: begin
        c.mc   = 1'b1;
        c.move = 1'b1;
        c.dir  = DIR_BACK;
        c.busy = 1'b1;
      end
      ST_RELEASE: begin
        c.cnt_rst = 1'b1;
        c.done    = 1'b1;
        c.busy    = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/peak_hold.sv
// Peak tracker for one sweep: remembers the largest voltage sample and the
// position count at which it was first seen. Cleared when a new sweep is
// accepted; only samples presented with i_en are considered.
module peak_hold
  import tracker_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int VW = DEF_VW
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [VW-1:0] i_val,
  input  logic [CW-1:0] i_pos,
  output logic [VW-1:0] o_max_val,
  output logic [CW-1:0] o_max_pos
);

  logic [VW-1:0] r_max_val;
  logic [CW-1:0] r_max_pos;
  logic          w_capture;

  // Strict compare: an equal later sample does not move the recorded peak.
  assign w_capture = i_en && (i_val > r_max_val);

  // Peak value/position register with clear on new sweep.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_max_val <= '0;
      r_max_pos <= '0;
    end else if (i_clr) begin
      r_max_val <= '0;
      r_max_pos <= '0;
    end else if (w_capture) begin
      r_max_val <= i_val;
      r_max_pos <= i_pos;
    end
  end

  assign o_max_val = r_max_val;
  assign o_max_pos = r_max_pos;

endmodule

// File: rtl/sweep_sequencer.sv
// One-axis sweep sequencer: sweeps the servo forward while recording the
// photo-voltage peak, then drives back until the position count matches the
// peak position. Drives MC/CNT_RST of max_counter and watches its CNT_RU flag
// as a guard against a counter that has run dry.
module sweep_sequencer
  import tracker_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int VW = DEF_VW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic          LIMIT,
  input  logic [VW-1:0] VOLT,
  input  logic          VOLT_VALID,
  input  logic          CNT_RU,
  output logic          MC,
  output logic          CNT_RST,
  output logic          MOVE,
  output logic          DIR,
  output logic          BUSY,
  output logic          DONE,
  output logic          FAULT,
  output logic [VW-1:0] MAX_VAL,
  output logic [CW-1:0] MAX_POS
);

  localparam logic [CW-1:0] POS_ONE = CW'(1);

  // The forward sweep stops when the position count can no longer grow.
  function automatic logic f_pos_full(input logic [CW-1:0] p);
    return &p;
  endfunction

  sweep_state_t  r_state;
  sweep_state_t  w_state_nxt;
  logic [CW-1:0] r_pos;
  logic [CW-1:0] w_pos_nxt;
  logic          r_fault;
  logic          w_fault_nxt;
  sweep_ctl_t    r_ctl;
  sweep_ctl_t    w_ctl_nxt;
  logic          w_accept;
  logic          w_sample_en;
  logic [VW-1:0] w_max_val;
  logic [CW-1:0] w_max_pos;

  assign w_sample_en = (r_state == ST_SWEEP) && VOLT_VALID;

  peak_hold #(
    .CW (CW),
    .VW (VW)
  ) u_peak_hold (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clr     (w_accept),
    .i_en      (w_sample_en),
    .i_val     (VOLT),
    .i_pos     (r_pos),
    .o_max_val (w_max_val),
    .o_max_pos (w_max_pos)
  );

  // Next-state, position and fault logic; strobes decoded from the next state.
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_fault_nxt = r_fault;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CLEAR;
          w_pos_nxt   = '0;
          w_fault_nxt = 1'b0;
        end
      end
      ST_CLEAR: begin
        w_state_nxt = ST_SWEEP;
      end
      ST_SWEEP: begin
        // The cycle that leaves SWEEP does not advance pos, so pos stays on
        // the last position that was actually sampled.
        if (LIMIT) begin
          w_state_nxt = ST_ARM;
        end else if (f_pos_full(r_pos)) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = ST_ARM;
        end else begin
          w_pos_nxt = r_pos + POS_ONE;
        end
      end
      ST_ARM: begin
        w_pos_nxt   = r_pos - POS_ONE;
        w_state_nxt = ST_RETURN;
      end
      ST_RETURN: begin
        // Reaching the peak wins over the counter flag; an exhausted counter
        // means a zero-length sweep or a counter out of step with pos.
        if (r_pos == w_max_pos) begin
          w_state_nxt = ST_RELEASE;
        end else if (!CNT_RU) begin
          w_fault_nxt = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else begin
          w_pos_nxt = r_pos - POS_ONE;
        end
      end
      ST_RELEASE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_ctl_nxt = f_decode(w_state_nxt);
  end

  // State, position, fault and registered strobe outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_pos   <= '0;
      r_fault <= 1'b0;
      r_ctl   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_fault <= w_fault_nxt;
      r_ctl   <= w_ctl_nxt;
    end
  end

  assign MC      = r_ctl.mc;
  assign CNT_RST = r_ctl.cnt_rst;
  assign MOVE    = r_ctl.move;
  assign DIR     = r_ctl.dir;
  assign BUSY    = r_ctl.busy;
  assign DONE    = r_ctl.done;
  assign FAULT   = r_fault;
  assign MAX_VAL = w_max_val;
  assign MAX_POS = w_max_pos;

endmodule
